multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: chunk-serial ALU that handles CHUNK bits per cycle.
// An operation takes N = WIDTH/CHUNK cycles after it is accepted.
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   start           - request an operation (accepted only while ready)
//   ainvert/binvert - invert a / b; binvert is also the initial carry-in
//   op              - 00 AND, 01 OR, 10 ADD, 11 SLT
//   a, b            - operands
//   ready           - idle and able to accept start
//   done            - one-cycle completion pulse
//   result          - registered result, held until the next completion
//   overflow, carry_out, zero - registered flags
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_carry_out;
  logic             r_zero;

  logic             w_k_last;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum_ext;
  logic [CHUNK-1:0] w_chunk_res;
  logic             w_cin_msb;
  logic             w_cout;
  logic             w_ovf;
  logic             w_set;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_ovf_nxt;
  logic             w_cout_nxt;

  assign w_k_last = (r_k == KW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_k_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    if (r_state == S_IDLE) begin
      w_load = start;
    end else begin
      w_step = 1'b1;
      w_last = w_k_last;
    end
  end

  // Operands are shifted right each step, so the current chunk is always the low CHUNK bits
  assign w_a_chunk = r_a[CHUNK-1:0];
  assign w_b_chunk = r_b[CHUNK-1:0];
  assign w_sum_ext = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the chunk MSB recovered from the MSB sum bit; meaningful on the last chunk only
  assign w_cin_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum_ext[CHUNK-1];
  assign w_cout    = w_sum_ext[CHUNK];
  assign w_ovf     = w_cin_msb ^ w_cout;
  assign w_set     = w_sum_ext[CHUNK-1] ^ w_ovf;

  // Per-chunk result bits
  always_comb begin
    w_chunk_res = w_sum_ext[CHUNK-1:0];
    case (r_op)
      2'b00:   w_chunk_res = w_a_chunk & w_b_chunk;
      2'b01:   w_chunk_res = w_a_chunk | w_b_chunk;
      default: w_chunk_res = w_sum_ext[CHUNK-1:0];
    endcase
  end

  // Accumulator fills from the top; after N steps chunk 0 sits at the bottom
  assign w_acc_nxt = WIDTH'({w_chunk_res, r_acc} >> CHUNK);

  // Final result and flags, used on the last step
  always_comb begin
    w_result_nxt = w_acc_nxt;
    w_ovf_nxt    = 1'b0;
    w_cout_nxt   = 1'b0;
    case (r_op)
      2'b10: begin
        w_ovf_nxt  = w_ovf;
        w_cout_nxt = w_cout;
      end
      2'b11:   w_result_nxt = WIDTH'(w_set);
      default: w_result_nxt = w_acc_nxt;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_op        <= 2'b00;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_load) begin
        r_a     <= ainvert ? ~a : a;
        r_b     <= binvert ? ~b : b;
        r_op    <= op;
        r_carry <= binvert;
        r_k     <= '0;
        r_acc   <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_carry <= w_cout;
        r_k     <= r_k + KW'(1);
        r_acc   <= w_acc_nxt;
      end
      r_done <= w_last;
      if (w_last) begin
        r_result    <= w_result_nxt;
        r_overflow  <= w_ovf_nxt;
        r_carry_out <= w_cout_nxt;
        r_zero      <= (w_result_nxt == '0);
      end
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

endmodule
